gc_eval_engine: RTL and testbench
=================================

Name: gc_eval_engine

Overview:
- Half-gates evaluator: the evaluator-side counterpart of the team's per-gate garbling engine.
- Accepts one active label per input wire plus the two garbled-table rows of a gate, and produces the gate's active output label.
- Uses the same fixed-key AES tweak hash as the garbler.
- Processes one gate per cycle through a fixed-latency AES pipeline, followed by a credit-protected output buffer that absorbs downstream backpressure.

Parameters:
- S, 20, width of circuit id (cid) and gate id (gid).
- K, 128, label width; K/2 > S+1 required.
- OBUF_DEPTH, 16, output buffer entries; must be >= NR_AES+1 (NR_AES from MAC_H.vh).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- AES_expandedKey  in  128*(NR_AES+1)  fixed-key AES round keys; static while any gate is in flight.
- in_valid  in  1  gate offered.
- in_ready  out  1  gate may be accepted.
- is_xor  in  1  1 = free-XOR gate, 0 = half-gates AND-class gate.
- cid, gid  in  S each  circuit/gate ids used for the tweak.
- in0_label, in1_label  in  K each  active labels Wa, Wb.
- gt_row_0, gt_row_1  in  K each  garbled rows TG, TE (ignored when is_xor=1).
- out_valid  out  1  out_label valid.
- out_ready  in  1  consumer accepts out_label.
- out_label  out  K  active output label Wc.
- busy  out  1  any gate in flight or buffered.

Behaviour:
- Accept when in_valid & in_ready at a rising edge. All inputs are sampled only on that edge.
- Tweaks: tw0 = {(K/2-S)'0, cid, (K/2-S-1)'0, gid, 1'b0}; tw1 = the same with LSB 1.
- Hash: H(X,tw) = AES(X^tw) ^ (X^tw), using two AES_128 instances of NR_AES-cycle latency.
  - Wa, Wb, TG, TE, is_xor, cid and gid travel alongside the AES pipes in NR_AES-deep delay lines, as in the garbler.
- AND-class at AES exit, with sa=Wa[0], sb=Wb[0]:
  - WG = H(Wa,tw0) ^ (sa ? TG : 0)
  - WE = H(Wb,tw1) ^ (sb ? (TE ^ Wa) : 0)
  - Wc = WG ^ WE
- XOR-class: Wc = Wa ^ Wb. It still traverses the full pipeline so output order equals acceptance order.
- A non-accepting cycle injects a bubble: a valid bit is carried in the delay line and the AES computes garbage that is discarded.
- Output buffer: FIFO with registered head. Wc is written in the cycle its valid bit leaves the pipeline. out_valid = buffer non-empty; the head pops on out_valid & out_ready.
- Latency, empty buffer: out_valid rises exactly NR_AES+1 cycles after the accept edge. Throughput is 1 gate/cycle while out_ready=1.
- Credit counters:
  - inflight (0..NR_AES): +1 on accept, -1 on pipeline exit, net 0 when both occur in the same cycle.
  - count (0..OBUF_DEPTH): +1 on write, -1 on pop.
  - in_ready = (inflight + count) < OBUF_DEPTH, computed combinationally from registered counters. The buffer therefore never overflows; there is no drop path.
  - Buffer full with a simultaneous write and pop: both occur and count is unchanged.
  - Buffer empty with a simultaneous write: no bypass; the entry appears the next cycle.
- busy = (inflight != 0) | (count != 0).
- Reset (rst low, asynchronous):
  - out_valid=0, out_label=0, in_ready=0, busy=0.
  - Counters, pointers and delay-line valid bits are cleared.
  - In-flight gates are discarded; AES data registers need not reset.
  - in_ready goes to 1 on the first clock after release.
- out_label holds its value while out_valid & ~out_ready.

Test Plan:
- XOR gate: Wa=0x0123...EF, Wb=0xFFFF...0000, is_xor=1, out_ready=1 -> out_valid exactly NR_AES+1 cycles later, out_label=Wa^Wb.
- AND gate, all four (sa,sb) combinations: labels and rows from a software half-gates model using the same expanded key, cid=5, gid=0..3 -> out_label matches the model's true output label.
- Streaming: 1000 random mixed gates back-to-back with out_ready=1 -> in_ready never drops, outputs appear in order with one result per cycle.
- Backpressure: out_ready=0 while issuing continuously -> exactly OBUF_DEPTH gates accepted, in_ready=0 thereafter, no loss. Re-enable out_ready -> all OBUF_DEPTH results drain in order.
- Bubbles: random in_valid gaps and random out_ready -> result sequence equals the model's sequence; busy=0 after the final pop.
- Reset mid-stream: assert rst with 5 gates in flight and 3 buffered -> out_valid=0 and busy=0 immediately. After release, the next gate's result arrives after NR_AES+1 cycles, with no stale outputs.

Source files
------------

// File: rtl/gc_eval_engine_if.sv
// Gate-in / label-out handshake bundle for the half-gates evaluator.
interface gc_eval_engine_if #(
  parameter int S = 20,
  parameter int K = 128
);
  logic         in_valid;
  logic         in_ready;
  logic         is_xor;
  logic [S-1:0] cid;
  logic [S-1:0] gid;
  logic [K-1:0] in0_label;
  logic [K-1:0] in1_label;
  logic [K-1:0] gt_row_0;
  logic [K-1:0] gt_row_1;
  logic         out_valid;
  logic         out_ready;
  logic [K-1:0] out_label;

  modport master (
    output in_valid, is_xor, cid, gid, in0_label, in1_label, gt_row_0, gt_row_1, out_ready,
    input  in_ready, out_valid, out_label
  );
  modport slave (
    input  in_valid, is_xor, cid, gid, in0_label, in1_label, gt_row_0, gt_row_1, out_ready,
    output in_ready, out_valid, out_label
  );
endinterface

// File: rtl/gc_eval_engine.sv
// Half-gates evaluator: two fixed-key AES-128 pipelines (one round per stage)
// hash Wa^tw0 and Wb^tw1; the gate's sideband rides a matching delay line, the
// output label is combined at pipeline exit and parked in a credit-protected
// FIFO with a registered head. K must be 128 (one AES block per label).
module gc_eval_engine #(
  parameter  int S          = 20,
  parameter  int K          = 128,
  parameter  int OBUF_DEPTH = 16,
  localparam int NR_AES     = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [128*(NR_AES+1)-1:0] AES_expandedKey,
  gc_eval_engine_if.slave           bus,
  output logic                      busy
);
  localparam int CW = $clog2(OBUF_DEPTH + 1);
  localparam int AW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;

  typedef struct packed {
    logic         is_xor;
    logic [S-1:0] cid;
    logic [S-1:0] gid;
    logic [K-1:0] wa;
    logic [K-1:0] wb;
    logic [K-1:0] tg;
    logic [K-1:0] te;
  } sb_t;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254) followed by the affine map; 0 maps to 0x63.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s, r;
    s = a; r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  // One AES round; byte i of the state is bits [127-8i -: 8], column-major.
  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   o [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) b[i] = sbox(st[127-8*i -: 8]);
    for (int i = 0; i < 16; i++) o[i] = b[(i + 4*(i%4)) % 16];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = o[4*c]; a1 = o[4*c+1]; a2 = o[4*c+2]; a3 = o[4*c+3];
        o[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        o[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        o[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        o[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = o[i];
    return res ^ rk;
  endfunction

  function automatic logic [K-1:0] tweak(input logic [S-1:0] c, input logic [S-1:0] g,
                                         input logic lsb);
    return {{(K/2-S){1'b0}}, c, {(K/2-S-1){1'b0}}, g, lsb};
  endfunction

  logic                  w_acc, w_exv, w_pop, w_ld;
  logic [1:0][K-1:0]     w_x;
  sb_t                   w_in, w_ex;
  logic [K-1:0]          w_hg, w_he, w_wc;
  logic [CW:0]           w_sum;

  logic [NR_AES:1]       r_vld_pipe;
  logic [1:0][K-1:0]     r_st [1:NR_AES];
  sb_t                   r_sb [1:NR_AES];
  logic [K-1:0]          r_mem [OBUF_DEPTH];
  logic [AW-1:0]         r_wp, r_rp;
  logic [CW-1:0]         r_infl, r_cnt, r_mcnt;
  logic                  r_hv, r_rdy;
  logic [K-1:0]          r_head;

  assign w_in  = '{is_xor: bus.is_xor, cid: bus.cid, gid: bus.gid, wa: bus.in0_label,
                   wb: bus.in1_label, tg: bus.gt_row_0, te: bus.gt_row_1};
  assign w_acc = bus.in_valid & bus.in_ready;
  assign w_x[0] = bus.in0_label ^ tweak(bus.cid, bus.gid, 1'b0);
  assign w_x[1] = bus.in1_label ^ tweak(bus.cid, bus.gid, 1'b1);

  // Per-lane AES pipeline; data runs every cycle, bubbles are simply ignored.
  for (genvar l = 0; l < 2; l++) begin : g_lane
    always_ff @(posedge clk) begin
      r_st[1][l] <= aes_round(w_x[l] ^ AES_expandedKey[127:0], AES_expandedKey[255:128], 1'b0);
      for (int s = 2; s <= NR_AES; s++)
        r_st[s][l] <= aes_round(r_st[s-1][l], AES_expandedKey[128*s +: 128], s == NR_AES);
    end
  end

  // Sideband delay line and buffer storage; valid bits live elsewhere.
  always_ff @(posedge clk) begin
    r_sb[1] <= w_in;
    for (int s = 2; s <= NR_AES; s++) r_sb[s] <= r_sb[s-1];
    if (w_exv) r_mem[r_wp] <= w_wc;
  end

  // Half-gates combine at pipeline exit; XOR gates bypass the hashes.
  assign w_ex  = r_sb[NR_AES];
  assign w_exv = r_vld_pipe[NR_AES];
  assign w_hg  = r_st[NR_AES][0] ^ w_ex.wa ^ tweak(w_ex.cid, w_ex.gid, 1'b0);
  assign w_he  = r_st[NR_AES][1] ^ w_ex.wb ^ tweak(w_ex.cid, w_ex.gid, 1'b1);
  assign w_wc  = w_ex.is_xor ? (w_ex.wa ^ w_ex.wb)
               : (w_hg ^ (w_ex.wa[0] ? w_ex.tg : '0)) ^
                 (w_he ^ (w_ex.wb[0] ? (w_ex.te ^ w_ex.wa) : '0));

  assign w_pop = r_hv & bus.out_ready;
  assign w_ld  = (r_mcnt != '0) & (~r_hv | w_pop);
  // Credits cover every gate in flight, so an accepted gate always has a slot.
  assign w_sum = {1'b0, r_infl} + {1'b0, r_cnt};

  assign bus.in_ready  = r_rdy & (w_sum < (CW+1)'(OBUF_DEPTH));
  assign bus.out_valid = r_hv;
  assign bus.out_label = r_head;
  assign busy          = (r_infl != '0) | (r_cnt != '0);

  // Valid shift register, credit counters, FIFO pointers and registered head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_pipe <= '0;
      r_infl     <= '0;
      r_cnt      <= '0;
      r_mcnt     <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_hv       <= 1'b0;
      r_head     <= '0;
      r_rdy      <= 1'b0;
    end else begin
      r_rdy      <= 1'b1;
      r_vld_pipe <= {r_vld_pipe[NR_AES-1:1], w_acc};
      unique case ({w_acc, w_exv})
        2'b10:   r_infl <= r_infl + CW'(1);
        2'b01:   r_infl <= r_infl - CW'(1);
        default: ;
      endcase
      r_cnt  <= r_cnt + CW'(w_exv) - CW'(w_pop);
      r_mcnt <= r_mcnt + CW'(w_exv) - CW'(w_ld);
      if (w_exv) r_wp <= (r_wp == AW'(OBUF_DEPTH-1)) ? '0 : r_wp + AW'(1);
      if (w_ld) begin
        r_rp   <= (r_rp == AW'(OBUF_DEPTH-1)) ? '0 : r_rp + AW'(1);
        r_head <= r_mem[r_rp];
      end
      r_hv <= w_ld | (r_hv & ~w_pop);
    end
  end
endmodule

// File: tb/tb_gc_eval_engine.sv
// Bench for gc_eval_engine: software AES + half-gates garbler model, table
// vectors, scoreboard queue, streaming / backpressure / bubble / reset runs.
module tb_gc_eval_engine;
  localparam int S = 20, K = 128, D = 16, NR = 10;

  typedef struct {
    logic         xr;
    logic [S-1:0] cid, gid;
    logic [K-1:0] wa, wb, tg, te, exp;
  } vec_t;

  logic                 clk = 1'b0, rst = 1'b0, busy;
  logic [128*(NR+1)-1:0] xkey;
  gc_eval_engine_if #(.S(S), .K(K)) bus();

  gc_eval_engine #(.S(S), .K(K), .OBUF_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .AES_expandedKey(xkey), .bus(bus), .busy(busy));

  always #5 clk = ~clk;

  int checks = 0, fails = 0, pops = 0, cyc = 0, stalls = 0;
  logic [K-1:0] exp_q[$];
  logic [7:0]   sb[256];
  logic [127:0] rk[11];

  function automatic void chk(string nm, logic [K-1:0] act, logic [K-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endfunction

  // ---------------- software AES-128 (table S-box, textbook rounds) --------
  function automatic logic [7:0] rl(logic [7:0] b, int n);
    return (b << n) | (b >> (8 - n));
  endfunction
  function automatic logic [7:0] x2(logic [7:0] b);
    return (b << 1) ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic void build_sbox();
    logic [7:0] p, q;
    p = 8'h01; q = 8'h01;
    for (int n = 0; n < 255; n++) begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1); q = q ^ (q << 2); q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      sb[p] = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4) ^ 8'h63;
    end
    sb[0] = 8'h63;
  endfunction
  function automatic void expand(logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = x2(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) begin
      rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      xkey[128*r +: 128] = rk[r];
    end
  endfunction
  function automatic logic [127:0] aes(logic [127:0] pt);
    logic [7:0] st[16], t[16], a[4];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[st[i]];
      for (int rw = 0; rw < 4; rw++)
        for (int c = 0; c < 4; c++) st[4*c+rw] = t[4*((c+rw)%4)+rw];
      if (r < 10)
        for (int c = 0; c < 4; c++) begin
          for (int k = 0; k < 4; k++) a[k] = st[4*c+k];
          for (int k = 0; k < 4; k++)
            st[4*c+k] = x2(a[k]) ^ x2(a[(k+1)%4]) ^ a[(k+1)%4] ^ a[(k+2)%4] ^ a[(k+3)%4];
        end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[r][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = st[i];
    return o;
  endfunction

  function automatic logic [K-1:0] tw(logic [S-1:0] c, logic [S-1:0] g, logic b);
    return {{(K/2-S){1'b0}}, c, {(K/2-S-1){1'b0}}, g, b};
  endfunction
  function automatic logic [K-1:0] H(logic [K-1:0] x, logic [K-1:0] t);
    return aes(x ^ t) ^ x ^ t;
  endfunction
  function automatic logic [K-1:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Evaluator-side expectation for arbitrary (not garbler-consistent) inputs.
  function automatic vec_t rnd_vec();
    vec_t v;
    logic [K-1:0] t0, t1;
    v.xr = 1'($urandom_range(1)); v.cid = S'($urandom); v.gid = S'($urandom);
    v.wa = r128(); v.wb = r128(); v.tg = r128(); v.te = r128();
    t0 = tw(v.cid, v.gid, 1'b0); t1 = tw(v.cid, v.gid, 1'b1);
    if (v.xr) v.exp = v.wa ^ v.wb;
    else v.exp = H(v.wa, t0) ^ (v.wa[0] ? v.tg : '0) ^ H(v.wb, t1) ^ (v.wb[0] ? (v.te ^ v.wa) : '0);
    return v;
  endfunction

  // Garbler side: build a real AND gate and return the true output label.
  function automatic vec_t garble_and(logic [K-1:0] R, int g, logic sa, logic sb_);
    vec_t v;
    logic a, b, pa, pb;
    logic [K-1:0] A0, B0, t0, t1, wg0, we0;
    a = 1'($urandom_range(1)); b = 1'($urandom_range(1));
    A0 = r128(); A0[0] = sa ^ a; B0 = r128(); B0[0] = sb_ ^ b;
    pa = A0[0]; pb = B0[0];
    v.xr = 1'b0; v.cid = S'(5); v.gid = S'(g);
    t0 = tw(v.cid, v.gid, 1'b0); t1 = tw(v.cid, v.gid, 1'b1);
    v.tg = H(A0, t0) ^ H(A0 ^ R, t0) ^ (pb ? R : '0);
    wg0  = H(A0, t0) ^ (pa ? v.tg : '0);
    v.te = H(B0, t1) ^ H(B0 ^ R, t1) ^ A0;
    we0  = H(B0, t1) ^ (pb ? (v.te ^ A0) : '0);
    v.wa = a ? (A0 ^ R) : A0;
    v.wb = b ? (B0 ^ R) : B0;
    v.exp = wg0 ^ we0 ^ ((a & b) ? R : '0);
    return v;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", bus.out_label, 'x);
      else chk("sb_label", bus.out_label, exp_q.pop_front());
      pops++;
    end
  end

  // ---------------- drivers ----------------
  task automatic drv(vec_t v, bit valid, output bit acc);
    bus.in_valid = valid; bus.is_xor = v.xr; bus.cid = v.cid; bus.gid = v.gid;
    bus.in0_label = v.wa; bus.in1_label = v.wb; bus.gt_row_0 = v.tg; bus.gt_row_1 = v.te;
    @(negedge clk);
    acc = valid && bus.in_ready;
    if (acc) exp_q.push_back(v.exp);
    @(posedge clk); #1;
  endtask
  task automatic send(vec_t v);
    bit a;
    int n;
    n = 0;
    do begin drv(v, 1'b1, a); n++; end while (!a && n < 100);
    if (!a) chk("send_timeout", 0, 1);
    stalls += n - 1;
  endtask
  task automatic idle(int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drain(string nm);
    int n;
    bus.in_valid = 1'b0; n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(posedge clk); n++; end
    #1;
    chk(nm, K'(exp_q.size()), 0);
  endtask
  // Accepts v alone, then counts cycles from the accept edge to out_valid.
  task automatic latency(string nm, vec_t v);
    bit a;
    int k;
    drv(v, 1'b1, a);
    bus.in_valid = 1'b0;
    chk({nm, "_acc"}, K'(a), 1);
    k = 0;
    @(negedge clk);
    while (!bus.out_valid && k < 40) begin @(negedge clk); k++; end
    chk(nm, K'(k), K'(NR + 1));
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    fails++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    vec_t g;
    logic [K-1:0] R;
    bit a;
    int acc, p0, t1, t2;

    bus.in_valid = 0; bus.is_xor = 0; bus.cid = 0; bus.gid = 0; bus.out_ready = 1;
    bus.in0_label = 0; bus.in1_label = 0; bus.gt_row_0 = 0; bus.gt_row_1 = 0;
    build_sbox();
    expand(128'h000102030405060708090a0b0c0d0e0f);
    chk("aes_model_fips197", aes(128'h00112233445566778899aabbccddeeff),
        128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    expand(128'h2b7e151628aed2a6abf7158809cf4f3c);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", K'(bus.out_valid), 0);
    chk("rst_out_label", bus.out_label, 0);
    chk("rst_in_ready", K'(bus.in_ready), 0);
    chk("rst_busy", K'(busy), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", K'(bus.in_ready), 1);

    // vector table: XOR constant, four garbled AND gates, random extras
    tbl[0] = '{xr: 1'b1, cid: 0, gid: 0, wa: 128'h0123456789abcdef0123456789abcdef,
               wb: 128'hffffffffffffffff0000000000000000, tg: 0, te: 0,
               exp: 128'hfedcba98765432100123456789abcdef};
    R = r128(); R[0] = 1'b1;
    for (int i = 0; i < 4; i++) tbl[1+i] = garble_and(R, i, i[1], i[0]);
    for (int i = 5; i < 8; i++) tbl[i] = rnd_vec();

    latency("xor_latency", tbl[0]);
    drain("xor_drain");
    for (int i = 1; i < 8; i++) send(tbl[i]);
    drain("table_drain");

    // streaming: back-to-back, one result per cycle, no stalls
    stalls = 0; p0 = pops; t1 = -1; t2 = -1;
    fork
      begin
        for (int i = 0; i < 1000; i++) send(rnd_vec());
        bus.in_valid = 1'b0;
      end
      begin
        for (int n = 0; n < 1500 && t2 < 0; n++) begin
          @(posedge clk); #2;
          if (t1 < 0 && pops >= p0 + 1) t1 = cyc;
          if (pops >= p0 + 1000) t2 = cyc;
        end
      end
    join
    chk("stream_stalls", K'(stalls), 0);
    chk("stream_span", K'(t2 - t1), K'(999));
    drain("stream_drain");

    // backpressure: exactly D accepts, then in_ready stays low
    bus.out_ready = 1'b0; acc = 0; p0 = pops;
    g = rnd_vec();
    for (int i = 0; i < 40; i++) begin
      drv(g, 1'b1, a);
      if (a) begin acc++; g = rnd_vec(); end
    end
    bus.in_valid = 1'b0;
    chk("bp_accepts", K'(acc), K'(D));
    chk("bp_in_ready_low", K'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    drain("bp_drain");
    chk("bp_pops", K'(pops - p0), K'(D));

    // bubbles with random out_ready
    g = rnd_vec();
    for (int i = 0; i < 300; i++) begin
      bus.out_ready = 1'($urandom_range(1));
      drv(g, ($urandom_range(2) != 0), a);
      if (a) g = rnd_vec();
    end
    bus.out_ready = 1'b1;
    drain("bubble_drain");
    chk("bubble_busy_idle", K'(busy), 0);

    // reset with 5 gates in flight and 3 buffered
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(rnd_vec());
    idle(5);
    chk("pre_rst_busy", K'(busy), 1);
    chk("pre_rst_out_valid", K'(bus.out_valid), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", K'(bus.out_valid), 0);
    chk("mid_rst_busy", K'(busy), 0);
    chk("mid_rst_out_label", bus.out_label, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", K'(bus.in_ready), 1);
    latency("post_rst_latency", rnd_vec());
    drain("post_rst_drain");
    idle(20);
    chk("final_out_valid", K'(bus.out_valid), 0);
    chk("final_busy", K'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
